lcd_bar_checker: RTL and testbench

//  Receive-side checker for the LCD colour-bar stream. Samples HD/VD/DEN/R/G/B
//  at pixel rate, rebuilds pixel and line position from the sync signals, and

---
 rtl/lcd_bar_if.sv | 27 ++
 rtl/lcd_bar_checker.sv | 156 +++++++++++++++
 tb/tb_lcd_bar_checker.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bar_if.sv
// Video sample bundle and checker status for the LCD colour-bar stream.
interface lcd_bar_if #(
   parameter int ERR_W = 16
);
   logic             pce;
   logic             hd;
   logic             vd;
   logic             den;
   logic [7:0]       r;
   logic [7:0]       g;
   logic [7:0]       b;
   logic             locked;
   logic             frame_done;
   logic             frame_ok;
   logic [ERR_W-1:0] pix_err;
   logic             line_err;

   modport master (
      output pce, hd, vd, den, r, g, b,
      input  locked, frame_done, frame_ok, pix_err, line_err
   );

   modport slave (
      input  pce, hd, vd, den, r, g, b,
      output locked, frame_done, frame_ok, pix_err, line_err
   );
endinterface

// File: rtl/lcd_bar_checker.sv
// Receive-side checker for the 8-bar LCD colour pattern: rebuilds pixel and
// line position from VD/DEN, counts mismatching pixels and geometry faults,
// and reports once per frame on every VD falling edge.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  S_UNLOCKED | waiting for the first VD fall; DEN ignored, no reports
//  S_ARMED    | tracking lines/pixels; every VD fall closes a frame
module lcd_bar_checker #(
   parameter int H_ACTIVE = 800,
   parameter int V_ACTIVE = 480,
   parameter int BAR_W    = 100,
   parameter int NUM_BARS = 8,
   parameter int EDGE_TOL = 1,
   parameter int ERR_W    = 16
) (
   input  logic     clk_i,
   input  logic     rst_i,
   lcd_bar_if.slave bus_if
);
   localparam logic [0:0] S_UNLOCKED = 1'b0;
   localparam logic [0:0] S_ARMED    = 1'b1;

   localparam int BAR_BW = ($clog2(NUM_BARS + 1) < 3) ? 3 : $clog2(NUM_BARS + 1);
   localparam int IN_BW  = ($clog2(BAR_W) < 1) ? 1 : $clog2(BAR_W);

   localparam logic [BAR_BW-1:0] LAST_BAR = BAR_BW'(NUM_BARS);
   localparam logic [IN_BW-1:0]  IN_LO    = IN_BW'(EDGE_TOL);
   localparam logic [IN_BW-1:0]  IN_HI    = IN_BW'(BAR_W - 1 - EDGE_TOL);
   localparam logic [IN_BW-1:0]  IN_END   = IN_BW'(BAR_W - 1);
   localparam logic [10:0]       H_L      = 11'(H_ACTIVE);
   localparam logic [9:0]        V_L      = 10'(V_ACTIVE);

   logic [0:0]        state_q;
   logic              vd_q, den_q, line_act_q, geom_q;
   logic [10:0]       pix_q;
   logic [9:0]        line_q;
   logic [BAR_BW-1:0] bar_q;
   logic [IN_BW-1:0]  in_q;
   logic [ERR_W-1:0]  err_q;

   logic              locked_q, done_q, ok_q, line_err_q;
   logic [ERR_W-1:0]  pix_err_q;

   logic              vd_fall, den_rise, den_fall, px_valid, px_bad;
   logic              in_bars, edge_skip, close_line_err;
   logic [BAR_BW-1:0] cur_bar, nxt_bar;
   logic [IN_BW-1:0]  cur_in, nxt_in;
   logic [23:0]       exp_rgb;
   logic              unused_hd;

   assign unused_hd = bus_if.hd;

   assign vd_fall  = vd_q & ~bus_if.vd;
   assign den_rise = ~den_q & bus_if.den;
   assign den_fall = den_q & ~bus_if.den;
   assign px_valid = bus_if.pce & (state_q == S_ARMED) & ~vd_fall & bus_if.den
                   & (den_rise | line_act_q);

   // A VD fall during (or exactly at the end of) an active line discards it.
   assign close_line_err = geom_q | (line_act_q & den_q) | bus_if.den | (line_q != V_L);

   // Current pixel position, expected colour, edge skip and next position.
   always_comb begin
      cur_bar   = den_rise ? '0 : bar_q;
      cur_in    = den_rise ? '0 : in_q;
      in_bars   = (cur_bar != LAST_BAR);
      exp_rgb   = '0;
      if (in_bars) begin
         exp_rgb = {{8{~cur_bar[1]}}, {8{~cur_bar[2]}}, {8{~cur_bar[0]}}};
      end
      edge_skip = in_bars & ((cur_in < IN_LO) | (cur_in > IN_HI));
      px_bad    = px_valid & ~edge_skip & ({bus_if.r, bus_if.g, bus_if.b} != exp_rgb);
      nxt_in    = cur_in + 1'b1;
      nxt_bar   = cur_bar;
      if (cur_in == IN_END) begin
         nxt_in = '0;
         if (in_bars) begin
            nxt_bar = cur_bar + 1'b1;
         end
      end
   end

   // Sync-edge history, FSM, position/error counters and frame report.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_UNLOCKED;
         vd_q       <= 1'b0;
         den_q      <= 1'b0;
         line_act_q <= 1'b0;
         geom_q     <= 1'b0;
         pix_q      <= '0;
         line_q     <= '0;
         bar_q      <= '0;
         in_q       <= '0;
         err_q      <= '0;
         locked_q   <= 1'b0;
         done_q     <= 1'b0;
         ok_q       <= 1'b0;
         line_err_q <= 1'b0;
         pix_err_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (bus_if.pce) begin
            vd_q  <= bus_if.vd;
            den_q <= bus_if.den;
            if (vd_fall) begin
               if (state_q == S_ARMED) begin
                  done_q     <= 1'b1;
                  pix_err_q  <= err_q;
                  line_err_q <= close_line_err;
                  ok_q       <= (err_q == '0) & ~close_line_err;
                  locked_q   <= ~close_line_err;
               end
               state_q    <= S_ARMED;
               line_act_q <= 1'b0;
               geom_q     <= 1'b0;
               pix_q      <= '0;
               line_q     <= '0;
               bar_q      <= '0;
               in_q       <= '0;
               err_q      <= '0;
            end else if (state_q == S_ARMED) begin
               if (px_valid) begin
                  line_act_q <= 1'b1;
                  bar_q      <= nxt_bar;
                  in_q       <= nxt_in;
                  if (den_rise) begin
                     pix_q <= 11'd1;
                  end else if (pix_q != 11'h7FF) begin
                     pix_q <= pix_q + 1'b1;
                  end
               end
               if (px_bad && (err_q != '1)) begin
                  err_q <= err_q + 1'b1;
               end
               if (den_fall && line_act_q) begin
                  line_act_q <= 1'b0;
                  if (line_q != 10'h3FF) begin
                     line_q <= line_q + 1'b1;
                  end
                  if (pix_q != H_L) begin
                     geom_q <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign bus_if.locked     = locked_q;
   assign bus_if.frame_done = done_q;
   assign bus_if.frame_ok   = ok_q;
   assign bus_if.pix_err    = pix_err_q;
   assign bus_if.line_err   = line_err_q;
endmodule

// File: tb/tb_lcd_bar_checker.sv
// Randomised frame-level bench for lcd_bar_checker; two instances share the
// stimulus so the 8-bit error counter saturation is covered alongside 16-bit.
module tb_lcd_bar_checker;
   localparam int H  = 80;
   localparam int V  = 12;
   localparam int BW = 10;
   localparam int NB = 8;
   localparam int ET = 1;

   localparam logic [23:0] COLOURS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pce = 1'b0, hd = 1'b1, vd = 1'b1, den = 1'b0;
   logic [7:0] r = 8'h0, g = 8'h0, b = 8'h0;

   int checks = 0;
   int failures = 0;

   int m_err = 0;
   int m_lines = 0;
   bit m_geom = 1'b0;
   bit m_armed = 1'b0;

   lcd_bar_if #(.ERR_W(16)) bus_a ();
   lcd_bar_if #(.ERR_W(8))  bus_b ();

   assign bus_a.pce = pce;  assign bus_b.pce = pce;
   assign bus_a.hd  = hd;   assign bus_b.hd  = hd;
   assign bus_a.vd  = vd;   assign bus_b.vd  = vd;
   assign bus_a.den = den;  assign bus_b.den = den;
   assign bus_a.r   = r;    assign bus_b.r   = r;
   assign bus_a.g   = g;    assign bus_b.g   = g;
   assign bus_a.b   = b;    assign bus_b.b   = b;

   lcd_bar_checker #(.H_ACTIVE(H), .V_ACTIVE(V), .BAR_W(BW), .NUM_BARS(NB),
                     .EDGE_TOL(ET), .ERR_W(16)) dut_a (
      .clk_i(clk), .rst_i(rst), .bus_if(bus_a));

   lcd_bar_checker #(.H_ACTIVE(H), .V_ACTIVE(V), .BAR_W(BW), .NUM_BARS(NB),
                     .EDGE_TOL(ET), .ERR_W(8)) dut_b (
      .clk_i(clk), .rst_i(rst), .bus_if(bus_b));

   always #5 clk = ~clk;

   function automatic logic [23:0] bar_colour(input int p);
      if (p / BW >= NB) return 24'h000000;
      return COLOURS[p / BW];
   endfunction

   function automatic bit counted(input int p);
      int off;
      if (p / BW >= NB) return 1'b1;
      off = p % BW;
      return (off >= ET) && (off <= BW - 1 - ET);
   endfunction

   // One sample with PCE high, then one idle clock (PCE every 2nd CLK).
   task automatic put(input logic h, input logic v, input logic d, input logic [23:0] c);
      @(negedge clk);
      pce = 1'b1; hd = h; vd = v; den = d; {r, g, b} = c;
      @(negedge clk);
      pce = 1'b0;
   endtask

   task automatic send_line(input int len, input bit shift, input int bad_pix,
                            input logic [23:0] bad_val, input bit all_bad, input bit rnd);
      logic [23:0] c;
      put(1'b0, 1'b1, 1'b0, 24'h0);
      put(1'b0, 1'b1, 1'b0, 24'h0);
      put(1'b1, 1'b1, 1'b0, 24'h0);
      put(1'b1, 1'b1, 1'b0, 24'h0);
      for (int p = 0; p < len; p++) begin
         c = (shift && p > 0) ? bar_colour(p - 1) : bar_colour(p);
         if (p == bad_pix || all_bad) c = bad_val;
         if (rnd && $urandom_range(15, 0) == 0) c = c ^ (24'd1 << $urandom_range(23, 0));
         if (c != bar_colour(p) && counted(p)) m_err++;
         put(1'b1, 1'b1, 1'b1, c);
      end
      put(1'b1, 1'b1, 1'b0, 24'h0);
      put(1'b1, 1'b1, 1'b0, 24'h0);
      m_lines++;
      if (len != H) m_geom = 1'b1;
   endtask

   task automatic send_frame(input int nlines, input int short_line, input bit shift,
                             input int bad_line, input int bad_pix, input logic [23:0] bad_val,
                             input bit all_bad, input bit rnd);
      for (int l = 0; l < nlines; l++) begin
         send_line((l == short_line) ? H - 1 : H, shift, (l == bad_line) ? bad_pix : -1,
                   bad_val, all_bad, rnd);
      end
   endtask

   // Drive a VD fall (optionally in the middle of an active line) and check the report.
   task automatic frame_close(input string tag, input bit partial);
      bit exp_le, exp_ok;
      int exp_pa, exp_pb;
      put(1'b1, 1'b1, 1'b0, 24'h0);
      if (partial) begin
         for (int p = 0; p < 3; p++) begin
            if (COLOURS[0] != bar_colour(p) && counted(p)) m_err++;
            put(1'b1, 1'b1, 1'b1, COLOURS[0]);
         end
         m_geom = 1'b1;
      end
      put(1'b1, 1'b0, partial, COLOURS[0]);
      checks++;
      if (bus_a.frame_done !== m_armed) begin
         failures++;
         $display("FAIL %s frame_done got %0b want %0b", tag, bus_a.frame_done, m_armed);
      end
      if (m_armed) begin
         exp_le = m_geom || (m_lines != V);
         exp_ok = (m_err == 0) && !exp_le;
         exp_pa = (m_err > 65535) ? 65535 : m_err;
         exp_pb = (m_err > 255) ? 255 : m_err;
         checks++;
         if (bus_a.pix_err !== 16'(exp_pa)) begin
            failures++;
            $display("FAIL %s pix_err16 got %0d want %0d", tag, bus_a.pix_err, exp_pa);
         end
         checks++;
         if (bus_b.pix_err !== 8'(exp_pb)) begin
            failures++;
            $display("FAIL %s pix_err8 got %0d want %0d", tag, bus_b.pix_err, exp_pb);
         end
         checks++;
         if (bus_a.line_err !== exp_le) begin
            failures++;
            $display("FAIL %s line_err got %0b want %0b", tag, bus_a.line_err, exp_le);
         end
         checks++;
         if (bus_a.frame_ok !== exp_ok || bus_b.frame_ok !== exp_ok) begin
            failures++;
            $display("FAIL %s frame_ok got %0b/%0b want %0b", tag, bus_a.frame_ok,
                     bus_b.frame_ok, exp_ok);
         end
         checks++;
         if (bus_a.locked !== !exp_le) begin
            failures++;
            $display("FAIL %s locked got %0b want %0b", tag, bus_a.locked, !exp_le);
         end
      end
      @(negedge clk);
      checks++;
      if (bus_a.frame_done !== 1'b0) begin
         failures++;
         $display("FAIL %s frame_done_pulse got %0b want 0", tag, bus_a.frame_done);
      end
      put(1'b1, 1'b0, partial, COLOURS[0]);
      put(1'b1, 1'b0, 1'b0, 24'h0);
      put(1'b1, 1'b1, 1'b0, 24'h0);
      m_err = 0; m_lines = 0; m_geom = 1'b0; m_armed = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if (bus_a.locked !== 1'b0 || bus_a.frame_done !== 1'b0 || bus_a.frame_ok !== 1'b0 ||
          bus_a.line_err !== 1'b0 || bus_a.pix_err !== 16'h0 || bus_b.pix_err !== 8'h0) begin
         failures++;
         $display("FAIL %s outputs got lk=%0b fd=%0b ok=%0b le=%0b pe=%0d/%0d want all 0", tag,
                  bus_a.locked, bus_a.frame_done, bus_a.frame_ok, bus_a.line_err,
                  bus_a.pix_err, bus_b.pix_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      m_armed = 1'b0;
   endtask

   task automatic test_ideal();
      frame_close("arm", 1'b0);
      send_frame(V, -1, 1'b0, -1, -1, 24'h0, 1'b0, 1'b0);
      frame_close("ideal1", 1'b0);
      send_frame(V, -1, 1'b0, -1, -1, 24'h0, 1'b0, 1'b0);
      frame_close("ideal2", 1'b0);
   endtask

   task automatic test_shifted_bars();
      send_frame(V, -1, 1'b1, -1, -1, 24'h0, 1'b0, 1'b0);
      frame_close("shifted", 1'b0);
   endtask

   task automatic test_single_error();
      send_frame(V, -1, 1'b0, 10, 25, 24'h00FF00, 1'b0, 1'b0);
      frame_close("single_err", 1'b0);
   endtask

   task automatic test_geometry();
      send_frame(V, 3, 1'b0, -1, -1, 24'h0, 1'b0, 1'b0);
      frame_close("short_line", 1'b0);
      send_frame(V, -1, 1'b0, -1, -1, 24'h0, 1'b0, 1'b0);
      frame_close("relock", 1'b0);
      send_frame(V - 1, -1, 1'b0, -1, -1, 24'h0, 1'b0, 1'b0);
      frame_close("few_lines", 1'b0);
      send_frame(V - 1, -1, 1'b0, -1, -1, 24'h0, 1'b0, 1'b0);
      send_line(1, 1'b0, -1, 24'h0, 1'b0, 1'b0);
      frame_close("one_px_line", 1'b0);
      send_frame(V, -1, 1'b0, -1, -1, 24'h0, 1'b0, 1'b0);
      frame_close("vd_in_den", 1'b1);
      send_frame(V, -1, 1'b0, -1, -1, 24'h0, 1'b0, 1'b0);
      frame_close("after_partial", 1'b0);
   endtask

   task automatic test_saturate();
      send_frame(V, -1, 1'b0, -1, -1, 24'hFFFFFF, 1'b1, 1'b0);
      frame_close("saturate", 1'b0);
   endtask

   task automatic test_random();
      int nl, sl;
      for (int f = 0; f < 4; f++) begin
         nl = V + (($urandom_range(3, 0) == 0) ? 1 : 0);
         sl = ($urandom_range(2, 0) == 0) ? int'($urandom_range(V - 1, 0)) : -1;
         send_frame(nl, sl, 1'b0, -1, -1, 24'h0, 1'b0, 1'b1);
         frame_close("random", 1'b0);
      end
   endtask

   task automatic test_midframe_reset();
      send_frame(6, -1, 1'b0, -1, -1, 24'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("midframe_rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_armed = 1'b0;
      send_frame(V - 6, -1, 1'b0, -1, -1, 24'h0, 1'b0, 1'b0);
      frame_close("rst_arm", 1'b0);
      send_frame(V, -1, 1'b0, -1, -1, 24'h0, 1'b0, 1'b0);
      frame_close("rst_clean", 1'b0);
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_shifted_bars();
      test_single_error();
      test_geometry();
      test_saturate();
      test_random();
      test_midframe_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
